// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch/LSU requesters, the arbiter and the memory unit.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port memory unit: fetch (read-only) and load/store.
// Each access runs IDLE -> ISSUE -> [WAIT -> RESP] with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int LW = $clog2(READ_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(READ_LAT);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;

  logic idle, p0_gnt, p1_gnt;

  // Load/store wins ties unless fetch has waited STARVE_MAX idle cycles.
  assign idle   = (state_q == S_IDLE);
  assign p0_gnt = idle & ~rst & bus.p0_req & (~bus.p1_req | (starve_q == STARVE_LIM));
  assign p1_gnt = idle & ~rst & bus.p1_req & ~p0_gnt;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (p0_gnt) begin
          mem_addr_d = bus.p0_addr;
          owner_d    = 1'b0;
          we_d       = 1'b0;
          state_d    = S_ISSUE;
        end else if (p1_gnt) begin
          mem_addr_d  = bus.p1_addr;
          mem_wdata_d = bus.p1_wdata;
          mem_we_d    = bus.p1_we;
          owner_d     = 1'b1;
          we_d        = bus.p1_we;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_q - LW'(1);
        if (lat_q == LW'(1)) begin
          if (owner_q) begin
            p1_rdata_d  = bus.mem_rdata;
            p1_rvalid_d = 1'b1;
          end else begin
            p0_rdata_d  = bus.mem_rdata;
            p0_rvalid_d = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (p0_gnt || !bus.p0_req) begin
      starve_d = '0;
    end else if (idle && starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: READ_LAT=1 and READ_LAT=2 instances, each with a simple memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus2 ();

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(2), .STARVE_MAX(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // One-cycle read latency memory for dut1
  logic [31:0] mem1 [0:1023];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    rd1 <= mem1[bus1.mem_addr];
  end
  assign bus1.mem_rdata = rd1;

  // Two-cycle read-only memory for dut2: address 0x004 holds an instruction word
  logic [31:0] rd2a, rd2b;
  always @(posedge clk) begin
    rd2a <= (bus2.mem_addr == 10'h004) ? 32'h00500093 : {22'h0, bus2.mem_addr};
    rd2b <= rd2a;
  end
  assign bus2.mem_rdata = rd2b;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic port; logic [31:0] data; } rexp_t;
  typedef struct { logic [9:0] addr; logic [31:0] data; } wexp_t;
  typedef struct { logic we; logic [9:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  rexp_t rq[$];
  wexp_t wq[$];
  vec_t  vecs[8];

  logic [111:0] outs1;
  assign outs1 = {bus1.p0_gnt, bus1.p0_rvalid, bus1.p0_rdata, bus1.p1_gnt, bus1.p1_rvalid,
                  bus1.p1_rdata, bus1.mem_addr, bus1.mem_wdata, bus1.mem_we, bus1.busy};

  // Scoreboard monitor for dut1: read responses and memory write pulses
  logic  prev_we = 1'b0;
  rexp_t re;
  wexp_t we_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.p0_rvalid || bus1.p1_rvalid) begin
        if (rq.size() == 0) chk("rvalid_unexpected", {bus1.p0_rvalid, bus1.p1_rvalid}, 2'b00);
        else begin
          re = rq.pop_front();
          chk("rvalid_port", {bus1.p0_rvalid, bus1.p1_rvalid}, re.port ? 2'b01 : 2'b10);
          chk("rdata", re.port ? bus1.p1_rdata : bus1.p0_rdata, re.data);
        end
      end
      if (bus1.mem_we) begin
        chk("mem_we_width", prev_we, 1'b0);
        if (wq.size() == 0) chk("mem_we_unexpected", bus1.mem_we, 1'b0);
        else begin
          we_e = wq.pop_front();
          chk("mem_write", {bus1.mem_addr, bus1.mem_wdata}, {we_e.addr, we_e.data});
        end
      end
    end
    prev_we <= bus1.mem_we;
  end

  task automatic p1_txn(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp);
    int   busy_n;
    int   rv_at;
    logic got;
    @(posedge clk); #1;
    bus1.p1_req = 1'b1; bus1.p1_we = we; bus1.p1_addr = addr; bus1.p1_wdata = wdata;
    if (we) wq.push_back(wexp_t'{addr, wdata});
    else    rq.push_back(rexp_t'{1'b1, exp});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus1.p1_gnt;
    end
    chk("p1_gnt", got, 1'b1);
    @(posedge clk); #1;
    bus1.p1_req = 1'b0;
    busy_n = 0;
    rv_at  = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus1.p1_rvalid) rv_at = n;
      if (!bus1.busy) break;
      busy_n++;
    end
    chk(we ? "busy_cycles_write" : "busy_cycles_read", busy_n, we ? 3'd1 : 3'd3);
    if (!we) chk("p1_rvalid_latency", rv_at, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   p1n, waits, cnt_g, cnt_we, rv_at, pulses;
    logic got, seen, p1rv;

    vecs[0] = '{1'b1, 10'h010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 10'h010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 10'h3FF, 32'hFE000000, 32'h0};
    vecs[3] = '{1'b1, 10'h3EF, 32'h00000005, 32'h0};
    vecs[4] = '{1'b0, 10'h3FF, 32'h0,        32'hFE000000};
    vecs[5] = '{1'b0, 10'h3EF, 32'h0,        32'h00000005};
    vecs[6] = '{1'b1, 10'h000, 32'h12345678, 32'h0};
    vecs[7] = '{1'b0, 10'h000, 32'h0,        32'h12345678};

    bus1.p0_req = 0; bus1.p0_addr = '0; bus1.p1_req = 0; bus1.p1_we = 0;
    bus1.p1_addr = '0; bus1.p1_wdata = '0;
    bus2.p0_req = 0; bus2.p0_addr = '0; bus2.p1_req = 0; bus2.p1_we = 0;
    bus2.p1_addr = '0; bus2.p1_wdata = '0;

    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", outs1, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Async reset in WAIT of a p1 read aborts it
    @(posedge clk); #1;
    bus1.p1_req = 1'b1; bus1.p1_we = 1'b0; bus1.p1_addr = 10'h3E9;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus1.p1_gnt; end
    chk("abort_gnt", got, 1'b1);
    @(posedge clk); #1 bus1.p1_req = 1'b0;
    @(posedge clk); #1 chk("abort_busy_before", bus1.busy, 1'b1);
    rst = 1'b1;
    #1 chk("abort_outputs", outs1, '0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= bus1.p1_rvalid | bus1.p0_rvalid; end
    chk("no_rvalid_after_reset", seen, 1'b0);
    chk("busy_after_reset", bus1.busy, 1'b0);

    for (int v = 0; v < 8; v++) p1_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp);

    // Both ports requesting continuously: fetch forced after STARVE_MAX p1 grants
    @(posedge clk); #1;
    bus1.p0_req = 1'b1; bus1.p0_addr = 10'h010;
    bus1.p1_req = 1'b1; bus1.p1_we = 1'b1; bus1.p1_addr = 10'h020; bus1.p1_wdata = 32'hA5A50001;
    p1n = 0; waits = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus1.p1_gnt) begin p1n++; wq.push_back(wexp_t'{10'h020, 32'hA5A50001}); end
      if (!bus1.busy && !bus1.p0_gnt) waits++;
      if (bus1.p0_gnt) begin got = 1'b1; rq.push_back(rexp_t'{1'b0, 32'hDEADBEEF}); end
    end
    @(posedge clk); #1 bus1.p0_req = 1'b0; bus1.p1_req = 1'b0;
    chk("starve_p0_gnt", got, 1'b1);
    chk("starve_p1_grants", p1n, 4);
    chk("starve_idle_waits", waits, 4);
    repeat (6) @(posedge clk);

    // Request raised and withdrawn while busy has no effect
    @(posedge clk); #1;
    bus1.p0_req = 1'b1; bus1.p0_addr = 10'h3FF;
    rq.push_back(rexp_t'{1'b0, 32'hFE000000});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus1.p0_gnt; end
    chk("withdraw_p0_gnt", got, 1'b1);
    @(posedge clk); #1;
    bus1.p0_req = 1'b0;
    bus1.p1_req = 1'b1; bus1.p1_we = 1'b1; bus1.p1_addr = 10'h055; bus1.p1_wdata = 32'h11111111;
    cnt_g = 0; cnt_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt_g  += int'(bus1.p1_gnt);
      cnt_we += int'(bus1.mem_we);
      if (i == 0) begin @(posedge clk); #1 bus1.p1_req = 1'b0; end
    end
    chk("withdraw_no_gnt", cnt_g, 0);
    chk("withdraw_no_we", cnt_we, 0);

    // Fetch read on the READ_LAT=2 instance
    @(posedge clk); #1;
    bus2.p0_req = 1'b1; bus2.p0_addr = 10'h004;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus2.p0_gnt; end
    chk("lat2_p0_gnt", got, 1'b1);
    @(posedge clk); #1 bus2.p0_req = 1'b0;
    rv_at = 0; pulses = 0; p1rv = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus2.p0_rvalid) begin pulses++; if (rv_at == 0) rv_at = n; end
      p1rv |= bus2.p1_rvalid;
    end
    chk("lat2_rvalid_at", rv_at, 4);
    chk("lat2_rvalid_pulses", pulses, 1);
    chk("lat2_p0_rdata", bus2.p0_rdata, 32'h00500093);
    chk("lat2_p1_rvalid", p1rv, 1'b0);

    repeat (4) @(posedge clk);
    chk("read_queue_drained", rq.size(), 0);
    chk("write_queue_drained", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
